turn_scheduler: RTL and testbench

Sequences the per-turn time limit for the two-player VGA game. It holds whose turn it is and counts down the turn budget in whole seconds. A turn passes to the other player either when a valid move is reported or when the budget expires. It sits between the game-logic block (which reports moves and game end) and the VGA renderer (which displays the active player and the seconds remaining).

---
 rtl/turn_scheduler_pkg.sv | 15 +
 rtl/turn_scheduler_if.sv | 24 ++
 rtl/turn_scheduler_prescaler.sv | 32 +++
 rtl/turn_scheduler.sv | 100 ++++++++++
 tb/tb_turn_scheduler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/turn_scheduler_pkg.sv
// Shared types and constants for the two-player turn timer.
package turn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int SEC_W = 5;

endpackage

// File: rtl/turn_scheduler_if.sv
// Bundle of game-logic inputs and renderer-facing outputs of the turn timer.
interface turn_scheduler_if;
    import turn_pkg::*;

    logic             start;
    logic             move_valid;
    logic             game_over;
    logic             active_player;
    logic [SEC_W-1:0] seconds_left;
    logic             timeout;
    logic             sec_tick;
    logic             running;

    modport master (
        output start, move_valid, game_over,
        input  active_player, seconds_left, timeout, sec_tick, running
    );

    modport slave (
        input  start, move_valid, game_over,
        output active_player, seconds_left, timeout, sec_tick, running
    );

endinterface

// File: rtl/turn_scheduler_prescaler.sv
// Divides the system clock down to a one-cycle tick per elapsed second.
module second_prescaler #(
    parameter int CLOCK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLOCK_FREQ - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = enable && !clear && (r_count == TERM);

    // Outside the enabled window the count is parked at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear || !enable) begin
            r_count <= '0;
        end else if (r_count == TERM) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Tracks the active player and counts down the per-turn budget in seconds.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int TURN_SECONDS = 15
) (
    input  logic              clk,
    input  logic              rst,
    turn_scheduler_if.slave   bus
);

    localparam logic [SEC_W-1:0] RELOAD = SEC_W'(TURN_SECONDS);

    state_t           r_state, w_state_nx;
    logic             r_player, w_player_nx;
    logic [SEC_W-1:0] r_sec, w_sec_nx;
    logic             r_timeout, w_timeout_nx;
    logic             r_sec_tick, w_sec_tick_nx;
    logic             r_running;
    logic             w_tick;
    logic             w_clear;

    second_prescaler #(
        .CLOCK_FREQ (CLOCK_FREQ)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (r_state == TURN),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    // Priority inside a turn: game_over, then move_valid, then the second tick.
    always_comb begin
        w_state_nx    = r_state;
        w_player_nx   = r_player;
        w_sec_nx      = r_sec;
        w_timeout_nx  = 1'b0;
        w_sec_tick_nx = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nx  = TURN;
                    w_player_nx = P1;
                    w_sec_nx    = RELOAD;
                    w_clear     = 1'b1;
                end
            end
            TURN: begin
                if (bus.game_over) begin
                    w_state_nx = DONE;
                    w_clear    = 1'b1;
                end else if (bus.move_valid) begin
                    w_player_nx = ~r_player;
                    w_sec_nx    = RELOAD;
                    w_clear     = 1'b1;
                end else if (w_tick) begin
                    w_sec_tick_nx = 1'b1;
                    if (r_sec > SEC_W'(1)) begin
                        w_sec_nx = r_sec - SEC_W'(1);
                    end else begin
                        w_timeout_nx = 1'b1;
                        w_player_nx  = ~r_player;
                        w_sec_nx     = RELOAD;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_player   <= P1;
            r_sec      <= '0;
            r_timeout  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_player   <= w_player_nx;
            r_sec      <= w_sec_nx;
            r_timeout  <= w_timeout_nx;
            r_sec_tick <= w_sec_tick_nx;
            r_running  <= (w_state_nx == TURN);
        end
    end

    assign bus.active_player = r_player;
    assign bus.seconds_left  = r_sec;
    assign bus.timeout       = r_timeout;
    assign bus.sec_tick      = r_sec_tick;
    assign bus.running       = r_running;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a 10-cycle second and a 3-second turn.
module tb_turn_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    turn_scheduler_if bus();

    turn_scheduler #(
        .CLOCK_FREQ   (10),
        .TURN_SECONDS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting timeout and sec_tick pulses seen after each edge.
    task automatic run(input int n, output int n_to, output int n_st);
        n_to = 0;
        n_st = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.timeout)  n_to++;
            if (bus.sec_tick) n_st++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_running"}, 32'(bus.running), 0);
        check({tag, "_player"},  32'(bus.active_player), 0);
        check({tag, "_secs"},    32'(bus.seconds_left), 0);
        check({tag, "_timeout"}, 32'(bus.timeout), 0);
        check({tag, "_sectick"}, 32'(bus.sec_tick), 0);
    endtask

    initial begin
        int to_cnt, st_cnt;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.move_valid = 1'b0;
        bus.game_over  = 1'b0;
        step();
        step();
        check_reset_vals("rst0");

        // Start of game (edge k)
        rst = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_running", 32'(bus.running), 1);
        check("start_player",  32'(bus.active_player), 0);
        check("start_secs",    32'(bus.seconds_left), 3);
        run(9, to_cnt, st_cnt);
        check("pre_tick_count", 32'(st_cnt), 0);
        check("pre_tick_secs",  32'(bus.seconds_left), 3);
        step();
        check("tick1_pulse", 32'(bus.sec_tick), 1);
        check("tick1_secs",  32'(bus.seconds_left), 2);

        // Expiry at k+30, then again at k+60
        run(19, to_cnt, st_cnt);
        check("pre_exp_timeouts", 32'(to_cnt), 0);
        check("pre_exp_secs",     32'(bus.seconds_left), 1);
        step();
        check("exp1_timeout", 32'(bus.timeout), 1);
        check("exp1_sectick", 32'(bus.sec_tick), 1);
        check("exp1_player",  32'(bus.active_player), 1);
        check("exp1_secs",    32'(bus.seconds_left), 3);
        step();
        check("exp1_one_cycle", 32'(bus.timeout), 0);
        run(28, to_cnt, st_cnt);
        check("turn2_timeouts", 32'(to_cnt), 0);
        check("turn2_ticks",    32'(st_cnt), 2);
        step();
        check("exp2_timeout", 32'(bus.timeout), 1);
        check("exp2_player",  32'(bus.active_player), 0);
        check("exp2_secs",    32'(bus.seconds_left), 3);

        // Move at cycle 15 of a turn (turn began at t0)
        run(14, to_cnt, st_cnt);
        bus.move_valid = 1'b1;
        step();
        bus.move_valid = 1'b0;
        check("move_player",  32'(bus.active_player), 1);
        check("move_secs",    32'(bus.seconds_left), 3);
        check("move_sectick", 32'(bus.sec_tick), 0);
        run(9, to_cnt, st_cnt);
        check("post_move_no_tick", 32'(st_cnt), 0);
        step();
        check("post_move_tick", 32'(bus.sec_tick), 1);
        check("post_move_secs", 32'(bus.seconds_left), 2);

        // Move on the expiry cycle
        run(19, to_cnt, st_cnt);
        check("pre_mexp_timeouts", 32'(to_cnt), 0);
        check("pre_mexp_secs",     32'(bus.seconds_left), 1);
        bus.move_valid = 1'b1;
        step();
        bus.move_valid = 1'b0;
        check("mexp_player",  32'(bus.active_player), 0);
        check("mexp_timeout", 32'(bus.timeout), 0);
        check("mexp_sectick", 32'(bus.sec_tick), 0);
        check("mexp_secs",    32'(bus.seconds_left), 3);

        // game_over together with move_valid, mid-turn
        run(14, to_cnt, st_cnt);
        check("pre_go_secs", 32'(bus.seconds_left), 2);
        bus.game_over  = 1'b1;
        bus.move_valid = 1'b1;
        step();
        bus.game_over  = 1'b0;
        bus.move_valid = 1'b0;
        check("go_running", 32'(bus.running), 0);
        check("go_player",  32'(bus.active_player), 0);
        check("go_secs",    32'(bus.seconds_left), 2);
        check("go_timeout", 32'(bus.timeout), 0);

        // DONE ignores moves and holds values
        bus.move_valid = 1'b1;
        step();
        bus.move_valid = 1'b0;
        run(25, to_cnt, st_cnt);
        check("done_timeouts", 32'(to_cnt), 0);
        check("done_ticks",    32'(st_cnt), 0);
        check("done_player",   32'(bus.active_player), 0);
        check("done_secs",     32'(bus.seconds_left), 2);
        check("done_running",  32'(bus.running), 0);

        // Restart from DONE
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_running", 32'(bus.running), 1);
        check("restart_player",  32'(bus.active_player), 0);
        check("restart_secs",    32'(bus.seconds_left), 3);

        // Mid-turn reset with player 2 active
        run(4, to_cnt, st_cnt);
        bus.move_valid = 1'b1;
        step();
        bus.move_valid = 1'b0;
        check("pre_rst_player", 32'(bus.active_player), 1);
        run(12, to_cnt, st_cnt);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_reset_vals("midrst");
        run(3, to_cnt, st_cnt);
        check("idle_running", 32'(bus.running), 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("rst_start_running", 32'(bus.running), 1);
        check("rst_start_player",  32'(bus.active_player), 0);
        check("rst_start_secs",    32'(bus.seconds_left), 3);
        run(9, to_cnt, st_cnt);
        check("rst_start_no_tick", 32'(st_cnt), 0);
        step();
        check("rst_start_tick", 32'(bus.sec_tick), 1);
        check("rst_start_secs2", 32'(bus.seconds_left), 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
